mem_port_arbiter: RTL and testbench

- Shares the processor's single-port 16-bit data memory between two requesters: port A (CPU load/store path) and port B (FPGA-side loader/debug port that writes program/data and reads back results).
- Serialises accesses, applies round-robin or fixed priority, and sequences memory enable/write strobes and read-latency waits.
- Returns a one-cycle ack per completed access.
- Sits between the CPU datapath memory interface and the memory block inside the top-level integration schematic.

---
 rtl/mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single-port 16-bit data memory between two requesters:
//   port A : CPU load/store path
//   port B : FPGA-side loader / debug port
// Accesses are serialised through a four-state sequencer:
//   IDLE -> ISSUE -> (WAIT x RD_LAT) -> ACK -> IDLE
// Writes skip WAIT. Ties are broken round-robin, or always in favour of B
// when FIXED_PRI is set.
//
// Ports
//   CLK, reset            clock; synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   port A request, held stable until a_ack
//   a_ack, a_rdata        one-cycle completion pulse, read data for port A
//   b_*                   same set for port B
//   mem_en/mem_we/mem_addr/mem_wdata   memory strobes, address and data
//   mem_rdata             memory read data, valid RD_LAT cycles after mem_en
//   busy                  high whenever the sequencer is not in IDLE
//   last_grant            0 = A served last, 1 = B served last
//
// Every output comes straight from a flop. No combinational path runs from
// the req inputs to the memory strobes.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  output logic              a_ack,
  output logic [15:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [15:0]       b_wdata,
  output logic              b_ack,
  output logic [15:0]       b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              last_grant
);

  // The wait counter only has to hold RD_LAT-1.
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic [15:0]       a_rdata_q, a_rdata_d;
  logic [15:0]       b_rdata_q, b_rdata_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;

  logic              grant_valid;
  logic              grant_b;

  // Next-state logic: arbitration, access sequencing and read capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    grant_valid  = 1'b0;
    grant_b      = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req && b_req) begin
          grant_valid = 1'b1;
          if (FIXED_PRI != 0) begin
            grant_b = 1'b1;
          end else begin
            // Serve whichever port was not served last.
            grant_b = ~last_grant_q;
          end
        end else if (a_req) begin
          grant_valid = 1'b1;
          grant_b     = 1'b0;
        end else if (b_req) begin
          grant_valid = 1'b1;
          grant_b     = 1'b1;
        end else begin
          grant_valid = 1'b0;
          grant_b     = 1'b0;
        end

        if (grant_valid) begin
          owner_d      = grant_b;
          last_grant_d = grant_b;
          state_d      = ISSUE;
          if (grant_b) begin
            we_d    = b_we;
            addr_d  = b_addr;
            wdata_d = b_wdata;
          end else begin
            we_d    = a_we;
            addr_d  = a_addr;
            wdata_d = a_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        if (we_q) begin
          state_d = ACK;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          // Last wait cycle: mem_rdata is valid now, so it goes to the owner only.
          state_d = ACK;
          if (owner_q == OWN_B) begin
            b_rdata_d = mem_rdata;
          end else begin
            a_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Output flops load from the next state, so each strobe lines up with
    // the cycle its state is active.
    mem_en_d = (state_d == ISSUE);
    mem_we_d = (state_d == ISSUE) && we_d;
    a_ack_d  = (state_d == ACK) && (owner_d == OWN_A);
    b_ack_d  = (state_d == ACK) && (owner_d == OWN_B);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_A;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 16'h0000;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      a_rdata_q    <= 16'h0000;
      b_rdata_q    <= 16'h0000;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
    end
  end

  // The latched address and data stay on the memory bus between accesses.
  // The memory ignores them while mem_en is low.
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign busy       = busy_q;
  assign last_grant = last_grant_q;

  mem_port_arbiter_chk u_chk (
    .clk    (CLK),
    .reset  (reset),
    .a_ack  (a_ack_q),
    .b_ack  (b_ack_q),
    .mem_en (mem_en_q),
    .mem_we (mem_we_q),
    .busy   (busy_q)
  );

endmodule

// ---------------------------------------------------------------------------
// mem_port_arbiter_chk
//
// Protocol invariants for the arbiter's outputs.
// Ports: clk, reset (active-low), a_ack, b_ack, mem_en, mem_we, busy.
// ---------------------------------------------------------------------------
module mem_port_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic a_ack,
  input logic b_ack,
  input logic mem_en,
  input logic mem_we,
  input logic busy
);

  a_single_ack : assert property (@(posedge clk) disable iff (!reset) !(a_ack && b_ack));
  a_we_in_en   : assert property (@(posedge clk) disable iff (!reset) mem_we |-> mem_en);
  a_en_busy    : assert property (@(posedge clk) disable iff (!reset) mem_en |-> busy);
  a_ack_busy   : assert property (@(posedge clk) disable iff (!reset) (a_ack || b_ack) |-> busy);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Three DUTs share one clock:
//   u0 : RD_LAT=1, round-robin
//   u1 : RD_LAT=1, fixed priority (B wins ties)
//   u2 : RD_LAT=3, round-robin
// The reference model works at the transaction level. It predicts the arbitration
// winner from last_grant and the FIXED_PRI rule, tracks memory contents in an
// associative array, and holds the expected rdata for each port.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [NI];
  logic          a_req     [NI];
  logic          a_we      [NI];
  logic [AW-1:0] a_addr    [NI];
  logic [15:0]   a_wdata   [NI];
  logic          a_ack     [NI];
  logic [15:0]   a_rdata   [NI];
  logic          b_req     [NI];
  logic          b_we      [NI];
  logic [AW-1:0] b_addr    [NI];
  logic [15:0]   b_wdata   [NI];
  logic          b_ack     [NI];
  logic [15:0]   b_rdata   [NI];
  logic          mem_en    [NI];
  logic          mem_we    [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic [15:0]   mem_wdata [NI];
  logic [15:0]   mem_rdata [NI];
  logic          busy      [NI];
  logic          last_grant[NI];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [15:0] ref_mem [int];
  logic [15:0] exp_rd  [NI][2];
  bit          last_m  [NI];

  function automatic int key(input int k, input logic [AW-1:0] a);
    return k * 1024 + int'(a);
  endfunction

  // Contents of a word that was never written.
  function automatic logic [15:0] dflt(input int k, input logic [AW-1:0] a);
    return 16'(k * 4369) ^ {6'd0, a};
  endfunction

  function automatic logic [15:0] ref_read(input int k, input logic [AW-1:0] a);
    if (ref_mem.exists(key(k, a))) return ref_mem[key(k, a)];
    else return dflt(k, a);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W   (AW),
      .RD_LAT   ((g == 2) ? 3 : 1),
      .FIXED_PRI((g == 1) ? 1 : 0)
    ) u_dut (
      .CLK       (clk),
      .reset     (rst[g]),
      .a_req     (a_req[g]),
      .a_we      (a_we[g]),
      .a_addr    (a_addr[g]),
      .a_wdata   (a_wdata[g]),
      .a_ack     (a_ack[g]),
      .a_rdata   (a_rdata[g]),
      .b_req     (b_req[g]),
      .b_we      (b_we[g]),
      .b_addr    (b_addr[g]),
      .b_wdata   (b_wdata[g]),
      .b_ack     (b_ack[g]),
      .b_rdata   (b_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g]),
      .last_grant(last_grant[g])
    );

    // Memory model: read data is valid only in the capture cycle,
    // RD_LAT cycles after the mem_en cycle. Other cycles carry junk.
    int          cd      = 0;
    logic [15:0] rd_word = 16'h0000;
    always @(posedge clk) begin
      if (mem_en[g] === 1'b1 && mem_we[g] === 1'b0) begin
        cd      <= (g == 2) ? 3 : 1;
        rd_word <= ref_read(g, mem_addr[g]);
      end else if (cd > 0) begin
        cd <= cd - 1;
      end
    end
    assign mem_rdata[g] = (cd == 1) ? rd_word : 16'hDEAD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[u%0d]: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_quiet(input int k);
    chk("idle_mem_en", k, mem_en[k], 1'b0);
    chk("idle_mem_we", k, mem_we[k], 1'b0);
    chk("idle_a_ack", k, a_ack[k], 1'b0);
    chk("idle_b_ack", k, b_ack[k], 1'b0);
    chk("idle_busy", k, busy[k], 1'b0);
    chk("idle_last_grant", k, last_grant[k], last_m[k]);
    chk("idle_a_rdata", k, a_rdata[k], exp_rd[k][0]);
    chk("idle_b_rdata", k, b_rdata[k], exp_rd[k][1]);
  endtask

  // One access by one port on an idle DUT. Checks every cycle up to the ack.
  // With early set, the requester drops req right after the grant.
  task automatic xact(input int k, input int p, input logic we, input logic [AW-1:0] ad,
                      input logic [15:0] wd, input bit early);
    int t_ack;
    t_ack = we ? 2 : 2 + ((k == 2) ? 3 : 1);
    if (p == 0) begin
      a_req[k] = 1'b1; a_we[k] = we; a_addr[k] = ad; a_wdata[k] = wd;
    end else begin
      b_req[k] = 1'b1; b_we[k] = we; b_addr[k] = ad; b_wdata[k] = wd;
    end
    for (int i = 1; i <= t_ack; i++) begin
      tick();
      if (early && i == 1) begin
        a_req[k] = 1'b0;
        b_req[k] = 1'b0;
      end
      chk("mem_en", k, mem_en[k], (i == 1));
      chk("mem_we", k, mem_we[k], (i == 1) && we);
      if (i == 1) begin
        chk("mem_addr", k, mem_addr[k], ad);
        chk("grant", k, last_grant[k], p);
        if (we) chk("mem_wdata", k, mem_wdata[k], wd);
      end
      chk("a_ack", k, a_ack[k], (p == 0) && (i == t_ack));
      chk("b_ack", k, b_ack[k], (p == 1) && (i == t_ack));
      chk("busy", k, busy[k], 1'b1);
    end
    a_req[k] = 1'b0;
    b_req[k] = 1'b0;
    if (we) ref_mem[key(k, ad)] = wd;
    else exp_rd[k][p] = ref_read(k, ad);
    last_m[k] = (p == 1);
    chk("a_rdata", k, a_rdata[k], exp_rd[k][0]);
    chk("b_rdata", k, b_rdata[k], exp_rd[k][1]);
    tick();
    chk_quiet(k);
  endtask

  // Both ports write continuously. Port A wants na accesses and port B wants nb.
  // Each port re-raises its request straight after its own ack.
  task automatic contend(input int k, input int na, input int nb);
    int            left[2];
    int            p;
    logic [AW-1:0] ad[2];
    logic [15:0]   wd[2];
    left[0] = na;
    left[1] = nb;
    for (int q = 0; q < 2; q++) begin
      ad[q] = AW'($urandom_range(0, 63));
      wd[q] = 16'($urandom);
    end
    a_we[k] = 1'b1; a_addr[k] = ad[0]; a_wdata[k] = wd[0]; a_req[k] = (left[0] > 0);
    b_we[k] = 1'b1; b_addr[k] = ad[1]; b_wdata[k] = wd[1]; b_req[k] = (left[1] > 0);
    while (left[0] + left[1] > 0) begin
      if (left[0] > 0 && left[1] > 0) p = (k == 1) ? 1 : (last_m[k] ? 0 : 1);
      else p = (left[0] > 0) ? 0 : 1;
      tick();
      chk("c_mem_en", k, mem_en[k], 1'b1);
      chk("c_mem_we", k, mem_we[k], 1'b1);
      chk("c_mem_addr", k, mem_addr[k], ad[p]);
      chk("c_mem_wdata", k, mem_wdata[k], wd[p]);
      chk("c_grant", k, last_grant[k], p);
      tick();
      chk("c_a_ack", k, a_ack[k], (p == 0));
      chk("c_b_ack", k, b_ack[k], (p == 1));
      ref_mem[key(k, ad[p])] = wd[p];
      last_m[k] = (p == 1);
      left[p]--;
      ad[p] = AW'($urandom_range(0, 63));
      wd[p] = 16'($urandom);
      if (p == 0) begin
        a_req[k] = (left[0] > 0); a_addr[k] = ad[0]; a_wdata[k] = wd[0];
      end else begin
        b_req[k] = (left[1] > 0); b_addr[k] = ad[1]; b_wdata[k] = wd[1];
      end
      tick();
      chk("c_gap_busy", k, busy[k], 1'b0);
      chk("c_gap_ack", k, a_ack[k] | b_ack[k], 1'b0);
    end
  endtask

  initial begin
    int            k;
    int            p;
    logic          we;
    logic [AW-1:0] ad;

    // Reset hold: both ports request while all DUTs are held in reset.
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0;
      a_req[i] = 1'b1; a_we[i] = 1'b1; a_addr[i] = 10'h010; a_wdata[i] = 16'h1111;
      b_req[i] = 1'b1; b_we[i] = 1'b1; b_addr[i] = 10'h020; b_wdata[i] = 16'h2222;
      exp_rd[i][0] = 16'h0000;
      exp_rd[i][1] = 16'h0000;
      last_m[i] = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < NI; i++) chk_quiet(i);
    end

    // Round-robin: releasing reset lets A win first, then the ports alternate.
    rst[0] = 1'b1;
    contend(0, 3, 3);

    // Fixed priority: B wins the tie. If B keeps requesting, A is starved.
    rst[1] = 1'b1;
    contend(1, 1, 1);
    contend(1, 1, 3);

    // RD_LAT=3: write 0xBEEF through A, then read it back through B.
    a_req[2] = 1'b0;
    b_req[2] = 1'b0;
    rst[2] = 1'b1;
    tick();
    chk_quiet(2);
    xact(2, 0, 1'b1, 10'h3FF, 16'hBEEF, 1'b0);
    xact(2, 1, 1'b0, 10'h3FF, 16'h0000, 1'b0);

    // RD_LAT=1: A writes then reads back address 5.
    xact(0, 0, 1'b1, 10'h005, 16'h00F0, 1'b0);
    xact(0, 0, 1'b0, 10'h005, 16'h0000, 1'b0);

    // The requester drops req early, but the access still completes.
    xact(1, 0, 1'b1, 10'h033, 16'hC3C3, 1'b1);
    xact(1, 1, 1'b0, 10'h033, 16'h0000, 1'b1);

    // Randomised single-port traffic on all three DUTs.
    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, NI - 1);
      p  = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      ad = ($urandom_range(0, 3) == 0) ? 10'h3FF : AW'($urandom_range(0, 7));
      xact(k, p, we, ad, 16'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Reset in the middle of a read: no ack, and everything is cleared.
    xact(2, 0, 1'b0, 10'h3FF, 16'h0000, 1'b0);
    b_req[2] = 1'b1; b_we[2] = 1'b0; b_addr[2] = 10'h3FF;
    tick();
    chk("mr_issue", 2, mem_en[2], 1'b1);
    tick();
    chk("mr_wait_en", 2, mem_en[2], 1'b0);
    chk("mr_wait_busy", 2, busy[2], 1'b1);
    rst[2] = 1'b0;
    tick();
    b_req[2] = 1'b0;
    exp_rd[2][0] = 16'h0000;
    exp_rd[2][1] = 16'h0000;
    last_m[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk_quiet(2);
      if (c == 1) rst[2] = 1'b1;
      tick();
    end
    xact(2, 0, 1'b1, 10'h044, 16'h5A5A, 1'b0);
    xact(2, 0, 1'b0, 10'h044, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of run, required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
